message_receive: RTL and testbench

- Serial receiver for the modulation link. Recovers MSG_W-bit messages from the single-wire stream produced by the message transmitter.
- Frame format, as driven by the transmitter:
  - Line idles at 0.
  - Start bit is 1.
  - Then MSG_W data bits, MSB first.
  - Then an optional parity bit.
  - Then a stop bit of 0.
  - Every bit is held BIT_CYCLES clocks.
- Samples each bit at mid-period, delivers the message with a one-cycle valid pulse, and flags malformed frames.

---
 rtl/message_receive.sv | 156 +++++++++++++++
 tb/tb_message_receive.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/message_receive.sv
// Serial message receiver: start bit 1, MSG_W data bits MSB first, stop bit 0.
// Define MSG_PARITY_EN to insert an even-parity bit between the data and the stop bit.
module message_receive #(
    parameter int MSG_W      = 5,
    parameter int BIT_CYCLES = 16,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             SerIn,
    output logic [MSG_W-1:0] Msg,
    output logic             valid,
    output logic             err,
    output logic             busy
);

    localparam int IDX_W = $clog2(MSG_W + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_LOW
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [MSG_W-1:0] shreg_q, shreg_d;
    logic [MSG_W-1:0] msg_q, msg_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             perr;
    logic             half_tick;
    logic             full_tick;

    assign half_tick = (cnt_q == CNT_W'(BIT_CYCLES / 2 - 1));
    assign full_tick = (cnt_q == CNT_W'(BIT_CYCLES - 1));

`ifdef MSG_PARITY_EN
    logic par_q, par_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) par_q <= 1'b0;
        else       par_q <= par_d;
    end

    assign perr = ^{shreg_q, par_q};
`else
    assign perr = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shreg_q <= '0;
            msg_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
            msg_q   <= msg_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        msg_d   = msg_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
`ifdef MSG_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (SerIn) state_d = START;
            end
            START: begin
                if (half_tick) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = SerIn ? DATA : IDLE;
                end
            end
            DATA: begin
                if (full_tick) begin
                    cnt_d   = '0;
                    shreg_d = (shreg_q << 1) | MSG_W'(SerIn);
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == IDX_W'(MSG_W - 1)) begin
`ifdef MSG_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
            PARITY: begin
`ifdef MSG_PARITY_EN
                if (full_tick) begin
                    cnt_d   = '0;
                    par_d   = SerIn;
                    state_d = STOP;
                end
`else
                state_d = IDLE;
`endif
            end
            STOP: begin
                if (full_tick) begin
                    cnt_d = '0;
                    // Re-arm at the mid sample so a back-to-back start edge is not missed
                    if (SerIn) begin
                        err_d   = 1'b1;
                        state_d = WAIT_LOW;
                    end else if (perr) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        msg_d   = shreg_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            WAIT_LOW: begin
                cnt_d = '0;
                if (!SerIn) state_d = IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign Msg   = msg_q;
    assign valid = valid_q;
    assign err   = err_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_message_receive.sv
// Scoreboard bench for message_receive: expected outputs queued at stimulus
// time, popped and compared when valid/err pulses appear.
module tb_message_receive;

    localparam int MSG_W = 5;
    localparam int BITC  = 16;
`ifdef MSG_PARITY_EN
    localparam int NPAR  = 1;
`else
    localparam int NPAR  = 0;
`endif
    localparam int LAT   = BITC / 2 + BITC * (MSG_W + NPAR + 1) + 1;

    typedef struct {
        int             cyc;
        logic           is_err;
        logic [MSG_W-1:0] msg;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             SerIn = 1'b0;
    logic [MSG_W-1:0] Msg;
    logic             valid;
    logic             err;
    logic             busy;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sb[$];
    logic [MSG_W-1:0] last_good = '0;
    logic [MSG_W-1:0] prev_msg = '0;

    message_receive #(.MSG_W(MSG_W), .BIT_CYCLES(BITC), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .SerIn (SerIn),
        .Msg   (Msg),
        .valid (valid),
        .err   (err),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            prev_msg = '0;
        end else begin
            if (valid || err) begin
                check("excl", {31'd0, valid & err}, 32'd0);
                if (sb.size() == 0) begin
                    check("spurious", {30'd0, valid, err}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_cyc", cyc, e.cyc);
                    check("out_kind", {31'd0, err}, {31'd0, e.is_err});
                    check("out_msg", {27'd0, Msg}, {27'd0, e.msg});
                end
            end else begin
                check("msg_hold", {27'd0, Msg}, {27'd0, prev_msg});
            end
            prev_msg = Msg;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b);
        SerIn = b;
        tick(BITC);
    endtask

    task automatic send_frame(input logic [MSG_W-1:0] d, input logic bad_par,
                              input logic stop_v);
        exp_t e;
        logic ok;
        ok       = !stop_v && !(bad_par && NPAR == 1);
        e.cyc    = cyc + LAT;
        e.is_err = !ok;
        e.msg    = ok ? d : last_good;
        if (ok) last_good = d;
        sb.push_back(e);
        send_bit(1'b1);
        for (int i = MSG_W - 1; i >= 0; i--) send_bit(d[i]);
        if (NPAR == 1) send_bit((^d) ^ bad_par);
        send_bit(stop_v);
    endtask

    initial begin
        tick(3);
        check("rst_msg", {27'd0, Msg}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        tick(5);

        send_frame(5'b10110, 1'b0, 1'b0);
        tick(20);
        check("idle_busy", {31'd0, busy}, 32'd0);

        send_frame(5'b00001, 1'b0, 1'b0);
        send_frame(5'b11111, 1'b0, 1'b0);
        tick(20);

        SerIn = 1'b1;
        tick(3);
        SerIn = 1'b0;
        tick(2);
        check("glitch_busy", {31'd0, busy}, 32'd1);
        tick(10);
        check("glitch_idle", {31'd0, busy}, 32'd0);
        check("glitch_msg", {27'd0, Msg}, {27'd0, last_good});
        tick(10);

        send_frame(5'b01100, 1'b0, 1'b1);
        tick(50);
        check("stuck_busy", {31'd0, busy}, 32'd1);
        SerIn = 1'b0;
        tick(2);
        check("stuck_release", {31'd0, busy}, 32'd0);
        tick(40);
        check("no_retrigger", {31'd0, busy}, 32'd0);

        send_bit(1'b1);
        send_bit(1'b0);
        tick(BITC / 2);
        reset = 1'b1;
        SerIn = 1'b0;
        tick(1);
        reset = 1'b0;
        last_good = '0;
        check("abort_msg", {27'd0, Msg}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        tick(BITC * 8);
        send_frame(5'b01010, 1'b0, 1'b0);
        tick(20);

`ifdef MSG_PARITY_EN
        send_frame(5'b10110, 1'b1, 1'b0);
        tick(10);
        send_frame(5'b10110, 1'b0, 1'b0);
        tick(10);
        send_frame(5'b00011, 1'b1, 1'b0);
        tick(10);
`endif
        send_frame(5'b10101, 1'b0, 1'b0);
        tick(20);

        check("final_msg", {27'd0, Msg}, {27'd0, last_good});
        check("pending", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
